// File: rtl/adder4.sv
//------------------------------------------------------------------------------
// adder4
//   Free-running up-counter. The next count comes from an explicit ripple-carry
//   chain of full-adder cells, not from a behavioural '+'. Each clock adds the
//   constant STEP, modulo 2**WIDTH. There is no enable, no load and no overflow
//   flag.
//
// Parameters
//   WIDTH  counter/adder width in bits (>= 2)
//   STEP   constant addend per clock (1 .. 2**WIDTH-1)
//
// Ports
//   CLK    in   1      clock; state updates on the rising edge
//   RST_X  in   1      asynchronous active-low reset; forces CNT to 0
//   CNT    out  WIDTH  registered counter value
//------------------------------------------------------------------------------
module adder4 #(
   parameter int WIDTH = 4,
   parameter int STEP  = 1
) (
   input  logic             CLK,
   input  logic             RST_X,
   output logic [WIDTH-1:0] CNT
);

   // Reject illegal configurations while elaborating.
   if (WIDTH < 2) begin : g_bad_width
      $error("adder4: WIDTH must be >= 2");
   end
   if ((STEP < 1) || (longint'(STEP) > ((longint'(1) << WIDTH) - 1))) begin : g_bad_step
      $error("adder4: STEP must be in 1 .. 2**WIDTH-1");
   end

   localparam logic [WIDTH-1:0] LP_B = WIDTH'(STEP);

   logic [WIDTH-1:0] r_cnt;
   logic [WIDTH-1:0] w_sum;
   logic [WIDTH-1:0] w_carry;   // w_carry[i] is the carry into cell i

   assign w_carry[0] = 1'b0;

   for (genvar gi = 0; gi < WIDTH; gi++) begin : g_fa
      assign w_sum[gi] = r_cnt[gi] ^ LP_B[gi] ^ w_carry[gi];
      // The MSB cell's carry-out is dropped, which is what makes the count wrap.
      if (gi < WIDTH - 1) begin : g_co
         assign w_carry[gi+1] = (r_cnt[gi] & LP_B[gi])
                              | (w_carry[gi] & (r_cnt[gi] ^ LP_B[gi]));
      end
   end

   always_ff @(posedge CLK or negedge RST_X) begin
      if (!RST_X) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= w_sum;
      end
   end

   assign CNT = r_cnt;

endmodule

// File: tb/tb_adder4.sv
module tb_adder4;

   logic       clk;
   logic       rst_x;
   logic [3:0] cnt_a;   // WIDTH=4, STEP=1
   logic [3:0] cnt_c;   // WIDTH=4, STEP=3
   logic [7:0] cnt_w;   // WIDTH=8, STEP=1

   int total = 0;
   int bad   = 0;

   adder4 #(.WIDTH(4), .STEP(1)) u_a (.CLK(clk), .RST_X(rst_x), .CNT(cnt_a));
   adder4 #(.WIDTH(4), .STEP(3)) u_c (.CLK(clk), .RST_X(rst_x), .CNT(cnt_c));
   adder4 #(.WIDTH(8), .STEP(1)) u_w (.CLK(clk), .RST_X(rst_x), .CNT(cnt_w));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Assert reset on a falling edge, hold two cycles, release on a falling edge.
   task automatic do_reset();
      @(negedge clk);
      rst_x = 1'b0;
      repeat (2) @(negedge clk);
      rst_x = 1'b1;
   endtask

   task automatic test_reset();
      rst_x = 1'b1;
      #2;
      rst_x = 1'b0;
      #1;
      total++;
      if (cnt_a !== 4'd0 || cnt_c !== 4'd0 || cnt_w !== 8'd0) begin
         bad++;
         $display("FAIL reset_async: a=%0d c=%0d w=%0d required 0", cnt_a, cnt_c, cnt_w);
      end
      for (int i = 0; i < 2; i++) begin
         @(posedge clk);
         #1;
         total++;
         if (cnt_a !== 4'd0 || cnt_c !== 4'd0 || cnt_w !== 8'd0) begin
            bad++;
            $display("FAIL reset_hold[%0d]: a=%0d c=%0d w=%0d required 0",
                     i, cnt_a, cnt_c, cnt_w);
         end
      end
      @(negedge clk);
      rst_x = 1'b1;
   endtask

   task automatic test_count_wrap();
      logic [3:0] exp;
      do_reset();
      for (int k = 1; k <= 16; k++) begin
         @(posedge clk);
         #1;
         exp = 4'(k);
         total++;
         if (cnt_a !== exp) begin
            bad++;
            $display("FAIL count_wrap[%0d]: got %0d required %0d", k, cnt_a, exp);
         end
      end
   endtask

   task automatic test_run20();
      do_reset();
      repeat (20) @(posedge clk);
      #1;
      total++;
      if (cnt_a !== 4'd4) begin
         bad++;
         $display("FAIL run20: got %0d required 4", cnt_a);
      end
   endtask

   task automatic test_mid_reset();
      do_reset();
      repeat (9) @(posedge clk);
      #1;
      total++;
      if (cnt_a !== 4'd9) begin
         bad++;
         $display("FAIL mid_pre: got %0d required 9", cnt_a);
      end
      #2;
      rst_x = 1'b0;
      #1;
      total++;
      if (cnt_a !== 4'd0) begin
         bad++;
         $display("FAIL mid_async: got %0d required 0", cnt_a);
      end
      @(negedge clk);
      rst_x = 1'b1;
      for (int k = 1; k <= 3; k++) begin
         @(posedge clk);
         #1;
         total++;
         if (cnt_a !== 4'(k)) begin
            bad++;
            $display("FAIL mid_resume[%0d]: got %0d required %0d", k, cnt_a, k);
         end
      end
   endtask

   task automatic test_step3();
      logic [3:0] seq [8] = '{4'd0, 4'd3, 4'd6, 4'd9, 4'd12, 4'd15, 4'd2, 4'd5};
      do_reset();
      #1;
      for (int k = 0; k < 8; k++) begin
         if (k > 0) begin
            @(posedge clk);
            #1;
         end
         total++;
         if (cnt_c !== seq[k]) begin
            bad++;
            $display("FAIL step3[%0d]: got %0d required %0d", k, cnt_c, seq[k]);
         end
      end
   endtask

   task automatic test_width8();
      logic [7:0] exp;
      logic       seen_wrap;
      exp       = 8'd0;
      seen_wrap = 1'b0;
      do_reset();
      for (int k = 1; k <= 260; k++) begin
         @(posedge clk);
         #1;
         if (exp == 8'd255) seen_wrap = 1'b1;
         exp = exp + 8'd1;
         total++;
         if (cnt_w !== exp) begin
            bad++;
            $display("FAIL width8[%0d]: got %0d required %0d", k, cnt_w, exp);
         end
         if (k == 256) begin
            total++;
            if (cnt_w !== 8'd0) begin
               bad++;
               $display("FAIL width8_wrap: got %0d required 0", cnt_w);
            end
         end
      end
      total++;
      if (seen_wrap !== 1'b1) begin
         bad++;
         $display("FAIL width8_seen_wrap: got %0b required 1", seen_wrap);
      end
   endtask

   initial begin
      rst_x = 1'b1;
      test_reset();
      test_count_wrap();
      test_run20();
      test_mid_reset();
      test_step3();
      test_width8();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
